// File: rtl/uart_input_fifo.sv
// UART receive front end: 2-flop synchroniser, frame decoder and show-ahead FIFO.
// Optional parity support is compiled in with `define UART_INPUT_PARITY_EN.
module uart_input_fifo #(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          uart_byte,
    output logic                          uart_byte_valid,
    input  logic                          uart_byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int BIT_CYC = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNTF_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BIT_CYC / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [CNTF_W-1:0] FULL_CNT = CNTF_W'(FIFO_DEPTH);

`ifdef UART_INPUT_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE
    } state_t;
`endif

    // Expected parity bit: odd mode makes total ones odd, even mode even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
        if (mode == 1) begin
            return ~(^d);
        end else begin
            return ^d;
        end
    endfunction

    logic [1:0]            sync_q;
    logic                  rxs;
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            bit_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  frame_err_q;
    logic                  par_bad_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  push_ok_s;
    logic [PTR_W-1:0]      wr_q;
    logic [PTR_W-1:0]      rd_q;
    logic [CNTF_W-1:0]     count_q;
    logic [CNTF_W-1:0]     count_d;
    logic                  overrun_q;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];

    assign rxs = sync_q[1];

    // Two-flop synchroniser for the asynchronous line, idle level 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

`ifdef UART_INPUT_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
    assign par_bad_s  = par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad_s  = 1'b0;
    assign parity_err = 1'b0 & (PARITY != 0);
`endif

    // Frame decoder; error pulses are registered on the stop-bit sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_INPUT_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_INPUT_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= 4'd0;
`ifdef UART_INPUT_PARITY_EN
                    par_bad_q <= 1'b0;
`endif
                    if (!rxs) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            bit_q <= 4'd0;
`ifdef UART_INPUT_PARITY_EN
                            state_q <= (PARITY != 0) ? ST_PAR : ST_STOP;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_INPUT_PARITY_EN
                ST_PAR: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= (rxs != parity_bit(shift_q, PARITY));
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end else begin
`ifdef UART_INPUT_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign frame_err = frame_err_q;

    // A good character completes on the stop-bit sample edge.
    always_comb begin
        push_s    = (state_q == ST_STOP) && (cnt_q == CNT_LAST) && rxs && !par_bad_s;
        pop_s     = (count_q != '0) && uart_byte_ready;
        full_s    = (count_q == FULL_CNT);
        push_ok_s = push_s && (!full_s || pop_s);
        if (push_ok_s && !pop_s) begin
            count_d = count_q + 1'b1;
        end else if (pop_s && !push_ok_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= push_s && full_s && !pop_s;
            if (push_ok_s) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_s) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= shift_q;
        end
    end

    // Show-ahead head output.
    always_comb begin
        if (count_q != '0) begin
            uart_byte = mem_q[rd_q];
        end else begin
            uart_byte = '0;
        end
    end

    assign uart_byte_valid = (count_q != '0);
    assign fifo_count      = count_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_uart_input_fifo.sv
// Directed bench for uart_input_fifo at a short bit period (BIT_CYC=50).
module tb_uart_input_fifo;

    localparam int BIT_CYC = 50;
`ifdef UART_INPUT_PARITY_EN
    localparam int TB_PARITY = 2;
`else
    localparam int TB_PARITY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_byte_ready = 1'b0;
    logic [7:0] uart_byte;
    logic       uart_byte_valid;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int fe_n = 0;
    int pe_n = 0;
    int ov_n = 0;
    int valid_n = 0;
    logic [7:0] popped[$];

    int fe_base, pe_base, ov_base, valid_base, pop_base;

    uart_input_fifo #(
        .CLK_FRE(50), .BAUD_RATE(1000000), .DATA_BITS(8),
        .PARITY(TB_PARITY), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .uart_byte(uart_byte), .uart_byte_valid(uart_byte_valid),
        .uart_byte_ready(uart_byte_ready), .fifo_count(fifo_count),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: pulse counts and popped characters.
    always @(negedge clk) begin
        if (frame_err) fe_n++;
        if (parity_err) pe_n++;
        if (overrun) ov_n++;
        if (uart_byte_valid) valid_n++;
        if (uart_byte_valid && uart_byte_ready) popped.push_back(uart_byte);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        fe_base = fe_n; pe_base = pe_n; ov_base = ov_n;
        valid_base = valid_n; pop_base = popped.size();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        uart_rx = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(BIT_CYC);
        end
`ifdef UART_INPUT_PARITY_EN
        uart_rx = (^d) ^ par_flip;
        tick(BIT_CYC);
`endif
        uart_rx = stop_bit;
        tick(BIT_CYC);
        if (!stop_bit) tick(2 * BIT_CYC);
        uart_rx = 1'b1;
        tick(BIT_CYC);
    endtask

    initial begin
        logic [7:0] d81;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_valid", 32'(uart_byte_valid), 32'd0);
        check_eq("rst_byte", 32'(uart_byte), 32'd0);
        check_eq("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        // Two characters straight through with the consumer ready.
        snap();
        uart_byte_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        tick(BIT_CYC);
        check_eq("t1_npop", 32'(popped.size() - pop_base), 32'd2);
        if (popped.size() >= pop_base + 2) begin
            check_eq("t1_b0", 32'(popped[pop_base]), 32'h55);
            check_eq("t1_b1", 32'(popped[pop_base + 1]), 32'hA3);
        end
        check_eq("t1_valid_beats", 32'(valid_n - valid_base), 32'd2);
        check_eq("t1_count", 32'(fifo_count), 32'd0);
        check_eq("t1_errs", 32'((fe_n - fe_base) + (pe_n - pe_base) + (ov_n - ov_base)), 32'd0);

        // Fill past capacity: only the seventeenth character overruns.
        snap();
        uart_byte_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0);
        check_eq("t2_count16", 32'(fifo_count), 32'd16);
        check_eq("t2_no_ovr_yet", 32'(ov_n - ov_base), 32'd0);
        send_frame(8'h10, 1'b1, 1'b0);
        check_eq("t2_ovr", 32'(ov_n - ov_base), 32'd1);
        check_eq("t2_count_full", 32'(fifo_count), 32'd16);
        check_eq("t2_head", 32'(uart_byte), 32'h00);
        uart_byte_ready = 1'b1;
        tick(40);
        check_eq("t2_npop", 32'(popped.size() - pop_base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (pop_base + i < popped.size())
                check_eq("t2_drain", 32'(popped[pop_base + i]), 32'(i));
        end
        check_eq("t2_count0", 32'(fifo_count), 32'd0);

        // Short low glitch is rejected at mid start bit.
        snap();
        uart_rx = 1'b0;
        tick(10);
        uart_rx = 1'b1;
        tick(2 * BIT_CYC);
        check_eq("t3_count", 32'(fifo_count), 32'd0);
        check_eq("t3_npop", 32'(popped.size() - pop_base), 32'd0);
        check_eq("t3_errs", 32'((fe_n - fe_base) + (pe_n - pe_base) + (ov_n - ov_base)), 32'd0);

        // Stop bit low: one frame error, then recovery.
        snap();
        uart_byte_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0);
        check_eq("t4_fe", 32'(fe_n - fe_base), 32'd1);
        check_eq("t4_pe", 32'(pe_n - pe_base), 32'd0);
        check_eq("t4_count", 32'(fifo_count), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0);
        check_eq("t4_count1", 32'(fifo_count), 32'd1);
        check_eq("t4_head", 32'(uart_byte), 32'h7E);
        uart_byte_ready = 1'b1;
        tick(3);
        check_eq("t4_drained", 32'(fifo_count), 32'd0);

`ifdef UART_INPUT_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        tick(3);
        check_eq("t5_npop", 32'(popped.size() - pop_base), 32'd1);
        if (popped.size() > pop_base) check_eq("t5_byte", 32'(popped[pop_base]), 32'h07);
        check_eq("t5_pe0", 32'(pe_n - pe_base), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        tick(3);
        check_eq("t5_pe1", 32'(pe_n - pe_base), 32'd1);
        check_eq("t5_nopush", 32'(popped.size() - pop_base), 32'd0);
        check_eq("t5_fe", 32'(fe_n - fe_base), 32'd0);
`endif

        // Reset in the middle of bit 4 with three bytes buffered.
        uart_byte_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        check_eq("t6_count3", 32'(fifo_count), 32'd3);
        snap();
        d81 = 8'h81;
        uart_rx = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            uart_rx = d81[i];
            tick(BIT_CYC);
        end
        uart_rx = d81[4];
        tick(BIT_CYC / 2);
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2 * BIT_CYC);
        check_eq("t6_count0", 32'(fifo_count), 32'd0);
        check_eq("t6_valid", 32'(uart_byte_valid), 32'd0);
        check_eq("t6_errs", 32'((fe_n - fe_base) + (pe_n - pe_base) + (ov_n - ov_base)), 32'd0);
        uart_byte_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0);
        tick(3);
        check_eq("t6_npop", 32'(popped.size() - pop_base), 32'd1);
        if (popped.size() > pop_base) check_eq("t6_byte", 32'(popped[pop_base]), 32'h81);
        check_eq("t6_count_end", 32'(fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_input_fifo.md
# uart_input_fifo

Parametrised UART receive front end: the successor to the fixed 8N1/115200, unbuffered receive path. It samples the asynchronous `uart_rx` pin and decodes frames with configurable baud, data width and parity. Good characters go into a show-ahead FIFO drained by a valid/ready handshake, so the 6502 bus side can stall without losing bytes. Framing, parity and overrun events are reported as single-cycle pulses.

## Interface
- `CLK_FRE`, 50: system clock in MHz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 16: entries; power of two, ≥2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `uart_rx` input 1: asynchronous serial line, idle high.
- `uart_byte` output DATA_BITS: FIFO head data, LSB = first received bit.
- `uart_byte_valid` output 1: FIFO non-empty.
- `uart_byte_ready` input 1: consumer accepts head this cycle.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: occupancy, 0..FIFO_DEPTH.
- `frame_err` output 1: one-cycle pulse, stop bit sampled low.
- `parity_err` output 1: one-cycle pulse, parity mismatch.
- `overrun` output 1: one-cycle pulse, good character dropped because FIFO full.

## Operation
- `uart_rx` passes through a 2-flop synchroniser; both flops reset to 1. All decode uses the synchronised value `rxs`.
- Bit period: BIT_CYC = CLK_FRE*1000000/BAUD_RATE, integer-truncated. One counter is sized for BIT_CYC-1.
- States: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE: on `rxs`==0, clear the counter and go to START.
- START: at count BIT_CYC/2 (mid start bit), sample `rxs`.
  - 1 is a glitch: return to IDLE, no flags.
  - 0: reset the counter and go to DATA.
- DATA: sample every BIT_CYC cycles into a shift register, LSB first. After DATA_BITS samples go to PAR if parity is enabled, else STOP.
- PAR: sample after BIT_CYC. Compare against the XOR of the data bits: odd requires total ones odd, even requires total ones even. Go to STOP.
- STOP: sample after BIT_CYC.
  - `rxs`==0: pulse `frame_err`, discard the character, go to WAIT_IDLE. This also covers break.
  - `rxs`==1 and parity failed: pulse `parity_err`, discard, go to IDLE.
  - `rxs`==1 and parity good: push to the FIFO, go to IDLE.
- WAIT_IDLE: stay until `rxs`==1, then go to IDLE. No new start bit is detected while in WAIT_IDLE.
- Only one error flag pulses per frame; frame error takes priority over parity error.
- FIFO:
  - Show-ahead: `uart_byte` = head entry whenever `uart_byte_valid`.
  - Pop when `uart_byte_valid && uart_byte_ready`.
  - Push when full with no pop in the same cycle: drop the new character, pulse `overrun`, leave FIFO contents intact.
  - Push and pop in the same cycle when full: accept the push, no overrun, count unchanged.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- `uart_byte_ready` while empty has no effect.

## Timing
- Reset values: state IDLE, counter 0, `fifo_count`=0, `uart_byte_valid`=0, `uart_byte`=0, all error pulses 0.
- Reset mid-frame aborts the frame with no push and no flags. The first cycle after reset deasserts is IDLE.
- Pin to detect latency: 2 cycles through the synchroniser plus 1 cycle for the IDLE decision.
- Stop-bit sample cycle: FIFO write and error pulses are registered on this edge. `uart_byte_valid` is high the next cycle when the FIFO was previously empty.
- Pop: `fifo_count` decrements and the next head appears on `uart_byte` the cycle after the handshake.
- Error pulses are exactly one clock wide.

## Configuration
- `UART_INPUT_PARITY_EN` defined: PAR state, parity compare and `parity_err` are compiled in, and the PARITY parameter is honoured.
- Undefined: PAR state is removed, frames are always treated as no-parity regardless of PARITY, and `parity_err` is tied to 0.

## Test plan
All scenarios use CLK_FRE=50, BAUD_RATE=115200 (BIT_CYC=434).
- 8N1, send 0x55 then 0xA3, `uart_byte_ready`=1 → two single-cycle valid beats with `uart_byte`=0x55 then 0xA3; `fifo_count` returns to 0; no error pulses.
- `uart_byte_ready`=0, send 17 characters 0x00..0x10 into FIFO_DEPTH=16 → `fifo_count`=16; exactly one `overrun` pulse, on character 0x10; draining yields 0x00..0x0F in order.
- Low glitch of 100 cycles on the idle line → no push, no flags, state back to IDLE.
- Frame 0x3C with stop bit driven low → one `frame_err` pulse, `fifo_count` stays 0; the next valid frame 0x7E is received after the line returns high.
- With `UART_INPUT_PARITY_EN`, PARITY=2: 0x07 with parity bit 1 → captured as 0x07; same frame with parity bit 0 → one `parity_err` pulse, nothing pushed.
- Assert `rst` for one cycle during bit 4 of a frame while the FIFO holds 3 bytes → `fifo_count`=0, valid low, no flags; the next full frame 0x81 is received correctly.
